// File: rtl/window_sum_pipe.sv
// window_sum_pipe -- pipelined signed adder tree over one window of elements.
//
// Sums N_ELEM packed two's-complement elements into one signed result. Level 0
// registers the sliced elements; each of the LOG2N following levels registers
// the adjacent pairwise sums (2j + 2j+1) of the level before it, growing one
// bit per level so nothing can overflow inside the tree. The last level feeds
// a combinational narrowing step onto out_sum.
//
// Flow control is a single global advance: every level moves forward together
// whenever the output is empty or being consumed, otherwise everything holds.
// Bubbles travel with the data and are never squeezed out.
//
// Configuration macro:
//   WINDOW_SUM_SAT_EN  defined   : narrowing saturates to the OUT_W signed range
//                      undefined : narrowing keeps the low OUT_W bits (wraps)
//   Either way the macro is irrelevant when OUT_W >= IN_W + LOG2N.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   window on in_data is valid
//   in_ready   block accepts in_data this cycle (= advance)
//   in_data    element i at in_data[IN_W*i +: IN_W]
//   out_valid  out_sum is valid
//   out_ready  consumer accepts out_sum
//   out_sum    signed window sum, OUT_W bits

// Sign-extending two-input adder: one instance per pair at every tree level.
module window_sum_add2 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W:0]   sum
);
   assign sum = {a[W-1], a} + {b[W-1], b};
endmodule

module window_sum_pipe #(
   parameter int N_ELEM = 8,
   parameter int IN_W   = 32,
   parameter int OUT_W  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N_ELEM*IN_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_sum
);
   localparam int LOG2N  = $clog2(N_ELEM);
   localparam int FULL_W = IN_W + LOG2N;

   logic adv;

   // One valid bit per level; bit LOG2N is the output valid.
   logic [LOG2N:0] vld_pipe_q, vld_pipe_d;

   assign out_valid = vld_pipe_q[LOG2N];
   // Advance when the output slot is empty or being drained this cycle.
   assign adv       = out_ready | ~out_valid;
   assign in_ready  = adv;

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      if (adv) vld_pipe_d = {vld_pipe_q[LOG2N-1:0], in_valid};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe_q <= '0;
      else        vld_pipe_q <= vld_pipe_d;
   end

   // Tree levels: level k holds N_ELEM>>k values of IN_W+k bits.
   for (genvar k = 0; k <= LOG2N; k++) begin : g_lvl
      localparam int W = IN_W + k;
      localparam int N = N_ELEM >> k;

      logic [W-1:0] val_q [N];
      logic [W-1:0] val_d [N];

      if (k == 0) begin : g_load
         always_comb begin
            for (int j = 0; j < N; j++) begin
               val_d[j] = val_q[j];
               if (adv) val_d[j] = in_data[IN_W*j +: IN_W];
            end
         end
      end else begin : g_add
         logic [W-1:0] pair_sum [N];

         for (genvar j = 0; j < N; j++) begin : g_pair
            window_sum_add2 #(.W(W-1)) u_add (
               .a   (g_lvl[k-1].val_q[2*j]),
               .b   (g_lvl[k-1].val_q[2*j+1]),
               .sum (pair_sum[j])
            );
         end

         always_comb begin
            for (int j = 0; j < N; j++) begin
               val_d[j] = val_q[j];
               if (adv) val_d[j] = pair_sum[j];
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int j = 0; j < N; j++) val_q[j] <= '0;
         end else begin
            for (int j = 0; j < N; j++) val_q[j] <= val_d[j];
         end
      end
   end

   // Final narrowing of the full-precision sum.
   logic [FULL_W-1:0] full_sum;
   assign full_sum = g_lvl[LOG2N].val_q[0];

   if (OUT_W >= FULL_W) begin : g_ext
      assign out_sum = OUT_W'($signed(full_sum));
   end else begin : g_narrow
`ifdef WINDOW_SUM_SAT_EN
      // The value fits when every bit from the OUT_W sign position upward
      // agrees; otherwise clamp toward the sign of the full sum.
      logic [FULL_W-OUT_W:0] top_bits;
      logic                  fits;

      assign top_bits = full_sum[FULL_W-1:OUT_W-1];
      assign fits     = (&top_bits) | ~(|top_bits);

      always_comb begin
         out_sum = full_sum[OUT_W-1:0];
         if (!fits) begin
            if (full_sum[FULL_W-1]) out_sum = {1'b1, {(OUT_W-1){1'b0}}};
            else                    out_sum = {1'b0, {(OUT_W-1){1'b1}}};
         end
      end
`else
      // Modulo 2^OUT_W, identical to an OUT_W-bit adder tree.
      assign out_sum = OUT_W'(full_sum);
`endif
   end

endmodule

// File: tb/tb_window_sum_pipe.sv
// Bench for window_sum_pipe (N_ELEM=8, IN_W=32, OUT_W=32). A queue-based model
// sums every accepted window with plain integer arithmetic; one negedge process
// compares each output handshake against it and watches stall/ready rules.
// Directed sequences pin the model with hand-computed literal values.
module tb_window_sum_pipe;
   localparam int N  = 8;
   localparam int IW = 32;
   localparam int OW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [N*IW-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [OW-1:0]   out_sum;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [OW-1:0] model_q[$];
   logic [OW-1:0] obs[$];
   int            obs_cyc[$];

   window_sum_pipe #(.N_ELEM(N), .IN_W(IW), .OUT_W(OW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: full-precision integer sum, then wrap or clamp to OW bits.
   function automatic logic [OW-1:0] model_sum(input logic [N*IW-1:0] d);
      longint s = 0;
      for (int i = 0; i < N; i++) s += longint'($signed(d[IW*i +: IW]));
`ifdef WINDOW_SUM_SAT_EN
      if (s > 64'sh7FFFFFFF)  return 32'h7FFFFFFF;
      if (s < -64'sh80000000) return 32'h80000000;
`endif
      return s[OW-1:0];
   endfunction

   function automatic logic [N*IW-1:0] pack8(input int e0, e1, e2, e3,
                                            input int e4, e5, e6, e7);
      return {e7, e6, e5, e4, e3, e2, e1, e0};
   endfunction

   function automatic logic [N*IW-1:0] fill(input logic [IW-1:0] v);
      logic [N*IW-1:0] d;
      for (int i = 0; i < N; i++) d[IW*i +: IW] = v;
      return d;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_obs(input int n, input string name);
      int i = 0;
      while (obs.size() < n && i < 60) begin
         step();
         i++;
      end
      chk(name, obs.size(), n);
   endtask

   // Compare process: all outputs checked every cycle against the model.
   initial begin
      logic          hold_pend = 1'b0;
      logic [OW-1:0] hold_sum  = '0;
      logic [OW-1:0] exp_v;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_q.delete();
            hold_pend = 1'b0;
            chk("rst_out_valid", out_valid, 0);
         end else begin
            if (hold_pend) begin
               chk("stall_hold_valid", out_valid, 1);
               chk("stall_hold_sum", out_sum, hold_sum);
            end
            if (!out_valid) chk("empty_in_ready", in_ready, 1);
            if (out_valid && !out_ready) begin
               chk("stall_in_ready", in_ready, 0);
               hold_pend = 1'b1;
               hold_sum  = out_sum;
            end else begin
               hold_pend = 1'b0;
            end
            if (in_valid && in_ready) model_q.push_back(model_sum(in_data));
            if (out_valid && out_ready) begin
               checks++;
               if (model_q.size() == 0) begin
                  errors++;
                  $display("FAIL out_extra: got %0h expected no output", out_sum);
               end else begin
                  exp_v = model_q.pop_front();
                  if (out_sum !== exp_v) begin
                     errors++;
                     $display("FAIL out_sum: got %0h expected %0h", out_sum, exp_v);
                  end
               end
               obs.push_back(out_sum);
               obs_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, p, idx, sent, t;
      logic acc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #3;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_sum", out_sum, 0);
      chk("reset_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // 1) elements 1..8, latency and single-cycle output
      out_ready = 1'b1;
      base = obs.size();
      in_valid = 1'b1; in_data = pack8(1, 2, 3, 4, 5, 6, 7, 8); p = cyc;
      step();
      in_valid = 1'b0;
      wait_obs(base + 1, "t1_count");
      if (obs.size() > base) begin
         chk("t1_sum", obs[base], 36);
         chk("t1_latency", obs_cyc[base] - p, 4);
      end
      chk("t1_valid_drop", out_valid, 0);

      // 2) all -1, then a mixed window whose elements cancel to 0
      base = obs.size();
      in_valid = 1'b1; in_data = fill(32'hFFFFFFFF); p = cyc;
      step();
      in_data = pack8(-5, 3, -100, 100, 7, -7, 0, 2);
      step();
      in_valid = 1'b0;
      wait_obs(base + 2, "t2_count");
      if (obs.size() > base + 1) begin
         chk("t2_sum_a", obs[base], 32'hFFFFFFF8);
         chk("t2_sum_b", obs[base+1], 0);
         chk("t2_consecutive", obs_cyc[base+1] - obs_cyc[base], 1);
      end

      // 3) extremes: narrowing policy
      base = obs.size();
      in_valid = 1'b1; in_data = fill(32'h7FFFFFFF);
      step();
      in_data = fill(32'h80000000);
      step();
      in_valid = 1'b0;
      wait_obs(base + 2, "t3_count");
      if (obs.size() > base + 1) begin
`ifdef WINDOW_SUM_SAT_EN
         chk("t3_pos", obs[base], 32'h7FFFFFFF);
         chk("t3_neg", obs[base+1], 32'h80000000);
`else
         chk("t3_pos", obs[base], 32'hFFFFFFF8);
         chk("t3_neg", obs[base+1], 32'h00000000);
`endif
      end
      repeat (3) step();

      // 4) six back-to-back windows (10..60), out_ready low for 3 cycles
      base = obs.size();
      idx = 0;
      for (int tt = 0; tt < 30; tt++) begin
         in_valid  = (idx < 6);
         in_data   = pack8(10 * (idx + 1) - 7, 1, 1, 1, 1, 1, 1, 1);
         out_ready = !(tt >= 3 && tt < 6);
         #1;
         if (tt == 3) chk("t4_empty_ready", in_ready, 1);
         if (tt == 4) begin
            chk("t4_stall_valid", out_valid, 1);
            chk("t4_stall_ready", in_ready, 0);
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         step();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("t4_count", obs.size() - base, 6);
      for (int k = 0; k < 6; k++)
         if (obs.size() > base + k) chk("t4_order", obs[base+k], 10 * (k + 1));

      // 5) random valid/ready over 10k windows
      sent = 0; t = 0;
      while (sent < 10000 && t < 40000) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            if ($urandom_range(0, 7) == 0)
               in_data = fill($urandom_range(0, 1) != 0 ? 32'h7FFFFFFF : 32'h80000000);
            else
               for (int i = 0; i < N; i++) in_data[IW*i +: IW] = $urandom();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = in_valid && in_ready;
         step();
         if (acc) begin
            sent++;
            in_valid = 1'b0;
         end
         t++;
      end
      chk("t5_sent", sent, 10000);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) step();
      chk("t5_drained", model_q.size(), 0);

      // 6) reset with three windows in flight
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_data = pack8(5 + k, 0, 0, 0, 0, 0, 0, 0);
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 10 && !out_valid; i++) step();
      chk("t6_pre_valid", out_valid, 1);
      chk("t6_pre_sum", out_sum, 5);
      rst_n = 1'b0;
      in_valid = 1'b1; in_data = pack8(999, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_sum", out_sum, 0);
      step();
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      base = obs.size();
      step();
      in_valid = 1'b1; in_data = pack8(70, 7, 0, 0, 0, 0, 0, 0); p = cyc;
      step();
      in_valid = 1'b0;
      wait_obs(base + 1, "t6_count");
      if (obs.size() > base) begin
         chk("t6_first_sum", obs[base], 77);
         chk("t6_latency", obs_cyc[base] - p, 4);
      end
      repeat (6) step();
      chk("t6_no_extra", obs.size() - base, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
